// File: rtl/exstage.sv
// Execute stage: latches the decoded bundle, runs the ALU, issues the data SRAM request
// and packs the execute-to-memory bus. Define EX_DIV_EN to include the iterative divider.
module exstage (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_validout,
  input  logic         ma_allowin,
  output logic         ex_allowin,
  output logic         ex_validout,
  input  logic [150:0] id_to_ex_bus,
  output logic [70:0]  ex_to_ma_bus,
  output logic [5:0]   ex_to_id_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  logic         r_valid;
  logic [150:0] r_bus;
  logic         w_readygo;
  logic [31:0]  w_alu, w_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else if (ex_allowin) begin
      r_valid <= id_validout;
      if (id_validout) r_bus <= id_to_ex_bus;
    end
  end

  logic [11:0] w_op;
  logic        w_res_from_mem, w_gr_we, w_mem_we;
  logic [4:0]  w_dest, w_shamt;
  logic [31:0] w_rkd, w_src1, w_src2, w_pc;

  assign w_op           = r_bus[147:136];
  assign w_res_from_mem = r_bus[135];
  assign w_gr_we        = r_bus[134];
  assign w_mem_we       = r_bus[133];
  assign w_dest         = r_bus[132:128];
  assign w_rkd          = r_bus[127:96];
  assign w_src2         = r_bus[95:64];
  assign w_src1         = r_bus[63:32];
  assign w_pc           = r_bus[31:0];
  assign w_shamt        = w_src2[4:0];

  logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sll, w_srl, w_sra;
  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'd0, $signed(w_src1) < $signed(w_src2)};
  assign w_sltu = {31'd0, w_src1 < w_src2};
  assign w_sll  = w_src1 << w_shamt;
  assign w_srl  = w_src1 >> w_shamt;
  assign w_sra  = $signed(w_src1) >>> w_shamt;

  // One-hot select; an all-zero op falls through to 0.
  assign w_alu = ({32{w_op[11]}} & w_add)  | ({32{w_op[10]}} & w_sub)
               | ({32{w_op[9]}}  & w_slt)  | ({32{w_op[8]}}  & w_sltu)
               | ({32{w_op[7]}}  & (w_src1 & w_src2))
               | ({32{w_op[6]}}  & ~(w_src1 | w_src2))
               | ({32{w_op[5]}}  & (w_src1 | w_src2))
               | ({32{w_op[4]}}  & (w_src1 ^ w_src2))
               | ({32{w_op[3]}}  & w_sll)  | ({32{w_op[2]}}  & w_srl)
               | ({32{w_op[1]}}  & w_sra)  | ({32{w_op[0]}}  & w_src2);

`ifdef EX_DIV_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo, r_rem, r_dvs;
  logic        r_qneg, r_rneg;
  logic        w_div_en, w_div_signed, w_div_rem;
  logic [31:0] w_abs1, w_abs2, w_div_res;
  logic [32:0] w_shift, w_diff;

  assign w_div_en     = r_bus[150];
  assign w_div_signed = r_bus[149];
  assign w_div_rem    = r_bus[148];
  assign w_abs1  = (w_div_signed & w_src1[31]) ? -w_src1 : w_src1;
  assign w_abs2  = (w_div_signed & w_src2[31]) ? -w_src2 : w_src2;
  // Restoring step: quotient register shifts its top bit into the partial remainder.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (r_valid & w_div_en) begin
          r_state <= S_BUSY;
          r_cnt   <= '0;
          r_quo   <= w_abs1;
          r_rem   <= '0;
          r_dvs   <= w_abs2;
          r_qneg  <= w_div_signed & (w_src1[31] ^ w_src2[31]);
          r_rneg  <= w_div_signed & w_src1[31];
        end
        S_BUSY: begin
          r_quo <= {r_quo[30:0], ~w_diff[32]};
          r_rem <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        S_DONE: if (ma_allowin) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Divide-by-zero bypasses the datapath; the bundle still holds the original dividend.
  assign w_div_res = (w_src2 == 32'd0) ? (w_div_rem ? w_src1 : 32'hFFFFFFFF)
                   : w_div_rem ? (r_rneg ? -r_rem : r_rem)
                               : (r_qneg ? -r_quo : r_quo);
  assign w_readygo = ~w_div_en | (r_state == S_DONE);
  assign w_result  = w_div_en ? w_div_res : w_alu;
`else
  logic w_unused_div;
  assign w_unused_div = ^r_bus[150:148];
  assign w_readygo    = 1'b1;
  assign w_result     = w_alu;
`endif

  assign ex_validout = r_valid & w_readygo;
  assign ex_allowin  = ~r_valid | (w_readygo & ma_allowin);

  assign ex_to_ma_bus = {w_res_from_mem, w_gr_we, w_dest, w_result, w_pc};
  assign ex_to_id_bus = {w_gr_we & r_valid, w_dest & {5{r_valid}}};

  // Request goes out in the hand-off cycle so read data lands in the first MA cycle.
  assign data_sram_en    = ex_validout & ma_allowin & (w_res_from_mem | w_mem_we);
  assign data_sram_we    = {4{w_mem_we & data_sram_en}};
  assign data_sram_addr  = w_alu;
  assign data_sram_wdata = w_rkd;

endmodule

// File: tb/tb_exstage.sv
// Bench for exstage: ALU vector table, store/load/reset sequences, divider cases when
// EX_DIV_EN is defined, and a randomized run against a behavioural model.
module tb_exstage;
  logic         clk = 1'b0;
  logic         rst, id_validout, ma_allowin;
  logic         ex_allowin, ex_validout;
  logic [150:0] id_to_ex_bus;
  logic [70:0]  ex_to_ma_bus;
  logic [5:0]   ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  always #5 clk = ~clk;

  exstage dut (
    .clk(clk), .rst(rst), .id_validout(id_validout), .ma_allowin(ma_allowin),
    .ex_allowin(ex_allowin), .ex_validout(ex_validout), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_ma_bus(ex_to_ma_bus), .ex_to_id_bus(ex_to_id_bus),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                          OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                          OP_OR = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                          OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;

  int nvec = 0, nerr = 0;

  typedef struct { logic [11:0] op; logic [31:0] a, b, exp; } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [150:0] mkbus(input logic de, ds, dr, input logic [11:0] op,
      input logic rfm, gwe, mwe, input logic [4:0] d, input logic [31:0] rkd, b, a, pc);
    return {de, ds, dr, op, rfm, gwe, mwe, d, rkd, b, a, pc};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
      OP_LUI:  return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic sgn, rem, input logic [31:0] a, b);
    longint la, lb, q, r;
    if (b == 32'd0) return rem ? a : 32'hFFFFFFFF;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return rem ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] ref_res(input logic [150:0] bus);
`ifdef EX_DIV_EN
    if (bus[150]) return ref_div(bus[149], bus[148], bus[63:32], bus[95:64]);
`endif
    return ref_alu(bus[147:136], bus[63:32], bus[95:64]);
  endfunction

`ifdef EX_DIV_EN
  task automatic div_run(input string nm, input logic sgn, rem, input logic [31:0] a, b,
                         input logic [31:0] exp);
    int n;
    id_to_ex_bus = mkbus(1'b1, sgn, rem, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0, b, a, 32'h2000);
    id_validout = 1'b1;
    ma_allowin = 1'b1;
    tick;
    id_validout = 1'b0;
    n = 0;
    while (!ex_validout && n < 60) begin
      if (ex_allowin !== 1'b0) chk({nm, "_allowin"}, 72'(ex_allowin), 72'(0));
      tick;
      n++;
    end
    chk({nm, "_latency"}, 72'(n), 72'(33));
    chk({nm, "_result"}, 72'(ex_to_ma_bus[63:32]), 72'(exp));
    tick;
  endtask
`endif

  logic         m_v, e_rg, e_vo, e_al, e_en;
  logic [150:0] m_b, nb;
  int           m_wait;

  initial begin
    tbl[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    tbl[1]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    tbl[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    tbl[3]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[4]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    tbl[5]  = '{OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F};
    tbl[6]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678};
    tbl[7]  = '{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    tbl[8]  = '{OP_SLL,  32'h00000001, 32'h0000003F, 32'h80000000};
    tbl[9]  = '{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000};
    tbl[10] = '{OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000};
    tbl[11] = '{OP_LUI,  32'h00000000, 32'hABCD0000, 32'hABCD0000};
    tbl[12] = '{12'h000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    rst = 1'b1; id_validout = 1'b0; ma_allowin = 1'b1; id_to_ex_bus = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_validout", 72'(ex_validout), 72'(0));
    chk("rst_allowin", 72'(ex_allowin), 72'(1));
    chk("rst_sram_en", 72'(data_sram_en), 72'(0));
    chk("rst_sram_we", 72'(data_sram_we), 72'(0));
    chk("rst_to_ma", 72'(ex_to_ma_bus), 72'(0));
    chk("rst_to_id", 72'(ex_to_id_bus), 72'(0));

    // Back-to-back ALU vectors, one per cycle.
    for (int i = 0; i < 13; i++) begin
      logic [4:0] d;
      d = 5'(i + 5);
      id_to_ex_bus = mkbus(1'b0, 1'b0, 1'b0, tbl[i].op, 1'b0, 1'b1, 1'b0, d, 32'h0,
                           tbl[i].b, tbl[i].a, 32'h1000 + 32'(4 * i));
      id_validout = 1'b1;
      tick;
      chk("alu_validout", 72'(ex_validout), 72'(1));
      chk("alu_to_ma", 72'(ex_to_ma_bus),
          72'({1'b0, 1'b1, d, tbl[i].exp, 32'h1000 + 32'(4 * i)}));
      chk("alu_to_id", 72'(ex_to_id_bus), 72'({1'b1, d}));
      chk("alu_sram_en", 72'(data_sram_en), 72'(0));
    end
    id_validout = 1'b0;
    tick;
    chk("drain_validout", 72'(ex_validout), 72'(0));
    chk("drain_to_id", 72'(ex_to_id_bus), 72'(0));

    // Store with immediate hand-off.
    id_to_ex_bus = mkbus(1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF,
                         32'h4, 32'h1000, 32'h3000);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    chk("st_en", 72'(data_sram_en), 72'(1));
    chk("st_we", 72'(data_sram_we), 72'(4'hF));
    chk("st_addr", 72'(data_sram_addr), 72'(32'h1004));
    chk("st_wdata", 72'(data_sram_wdata), 72'(32'hDEADBEEF));
    tick;
    // Store under back-pressure: no request until MA accepts.
    ma_allowin = 1'b0;
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_en", 72'(data_sram_en), 72'(0));
      chk("bp_we", 72'(data_sram_we), 72'(0));
      chk("bp_allowin", 72'(ex_allowin), 72'(0));
      chk("bp_hold", 72'(ex_to_ma_bus[63:32]), 72'(32'h1004));
      tick;
    end
    ma_allowin = 1'b1;
    #1;
    chk("bp_release_en", 72'(data_sram_en), 72'(1));
    chk("bp_release_we", 72'(data_sram_we), 72'(4'hF));
    chk("bp_allowin_rel", 72'(ex_allowin), 72'(1));
    tick;
    // Load: request enabled, no byte writes.
    id_to_ex_bus = mkbus(1'b0, 1'b0, 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0,
                         32'h10, 32'h2000, 32'h3004);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    chk("ld_en", 72'(data_sram_en), 72'(1));
    chk("ld_we", 72'(data_sram_we), 72'(0));
    chk("ld_addr", 72'(data_sram_addr), 72'(32'h2010));
    tick;

    // Reset while a bundle is held by back-pressure, then an sra.
    ma_allowin = 1'b0;
    id_to_ex_bus = mkbus(1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0,
                         32'h1, 32'h1, 32'h4000);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    chk("hold_validout", 72'(ex_validout), 72'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstmid_validout", 72'(ex_validout), 72'(0));
    chk("rstmid_allowin", 72'(ex_allowin), 72'(1));
    chk("rstmid_to_id", 72'(ex_to_id_bus), 72'(0));
    ma_allowin = 1'b1;
    id_to_ex_bus = mkbus(1'b0, 1'b0, 1'b0, OP_SRA, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0,
                         32'h4, 32'h80000000, 32'h4004);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    chk("sra_validout", 72'(ex_validout), 72'(1));
    chk("sra_result", 72'(ex_to_ma_bus[63:32]), 72'(32'hF8000000));
    tick;

`ifdef EX_DIV_EN
    div_run("sdiv_q", 1'b1, 1'b0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
    div_run("sdiv_r", 1'b1, 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
    div_run("udiv0_q", 1'b0, 1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF);
    div_run("udiv0_r", 1'b0, 1'b1, 32'h12345678, 32'h0, 32'h12345678);
    div_run("sdiv_ovf", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    div_run("sdiv_ovf_r", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    // Reset during BUSY, then a plain sra must complete in one cycle.
    id_to_ex_bus = mkbus(1'b1, 1'b1, 1'b0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0,
                         32'h3, 32'h64, 32'h5000);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    repeat (11) tick;
    chk("dbusy_allowin", 72'(ex_allowin), 72'(0));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("drst_validout", 72'(ex_validout), 72'(0));
    chk("drst_allowin", 72'(ex_allowin), 72'(1));
    id_to_ex_bus = mkbus(1'b0, 1'b0, 1'b0, OP_SRA, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0,
                         32'h4, 32'h80000000, 32'h5004);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    chk("drst_sra_vo", 72'(ex_validout), 72'(1));
    chk("drst_sra", 72'(ex_to_ma_bus[63:32]), 72'(32'hF8000000));
    tick;
`else
    // Divider control bits are ignored in this build.
    id_to_ex_bus = mkbus(1'b1, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0,
                         32'h4, 32'h3, 32'h6000);
    id_validout = 1'b1;
    tick;
    id_validout = 1'b0;
    chk("nodiv_validout", 72'(ex_validout), 72'(1));
    chk("nodiv_result", 72'(ex_to_ma_bus[63:32]), 72'(32'h7));
    tick;
`endif

    // Randomized traffic against a cycle-count model of the stage.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_v = 1'b0; m_b = '0; m_wait = 0;
    for (int c = 0; c < 1500; c++) begin
      int k;
      logic [11:0] op;
      k = $urandom_range(0, 12);
      op = (k == 12) ? 12'h0 : 12'(1 << k);
      nb = mkbus(1'($urandom % 8 == 0), 1'($urandom % 2), 1'($urandom % 2), op,
                 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 5'($urandom),
                 $urandom, ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom,
                 $urandom, $urandom);
      id_to_ex_bus = nb;
      id_validout = 1'($urandom % 2);
      ma_allowin = ($urandom % 4) != 0;
      #1;
      e_rg = (m_wait == 0);
      e_vo = m_v & e_rg;
      e_al = !m_v | (e_rg & ma_allowin);
      e_en = e_vo & ma_allowin & (m_b[135] | m_b[133]);
      chk("rnd_validout", 72'(ex_validout), 72'(e_vo));
      chk("rnd_allowin", 72'(ex_allowin), 72'(e_al));
      chk("rnd_to_id", 72'(ex_to_id_bus), 72'({m_b[134] & m_v, m_b[132:128] & {5{m_v}}}));
      chk("rnd_sram_en", 72'(data_sram_en), 72'(e_en));
      chk("rnd_sram_we", 72'(data_sram_we), 72'({4{e_en & m_b[133]}}));
      if (e_vo)
        chk("rnd_to_ma", 72'(ex_to_ma_bus),
            72'({m_b[135], m_b[134], m_b[132:128], ref_res(m_b), m_b[31:0]}));
      if (e_en) begin
        chk("rnd_addr", 72'(data_sram_addr), 72'(ref_alu(m_b[147:136], m_b[63:32], m_b[95:64])));
        chk("rnd_wdata", 72'(data_sram_wdata), 72'(m_b[127:96]));
      end
      @(posedge clk);
      if (e_al) begin
        m_v = id_validout;
        if (id_validout) begin
          m_b = nb;
          m_wait = 0;
`ifdef EX_DIV_EN
          if (nb[150]) m_wait = 33;
`endif
        end
      end else if (m_v && m_wait > 0) begin
        m_wait--;
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/exstage.md
# exstage

Execute stage of the five-stage in-order pipeline. It sits between decode and memory access. It latches the decoded bundle using the valid/allowin handshake and computes the ALU result. It issues the data SRAM request one cycle before the instruction occupies the memory-access stage, and packs the 71-bit execute-to-memory bus. An optional iterative divider stalls the stage by holding its ready-to-go low.

## Interface
Parameters: none.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- id_validout  input  1  decode stage presents a valid bundle
- ma_allowin  input  1  memory-access stage can accept this cycle
- ex_allowin  output  1  execute can accept a bundle from decode
- ex_validout  output  1  execute holds a finished, valid bundle
- id_to_ex_bus  input  151  bundle from decode:
  - [150] div_en, [149] div_signed, [148] div_rem
  - [147:136] alu_op, one-hot, in this bit order from 147 down to 136: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
  - [135] res_from_mem, [134] gr_we, [133] mem_we, [132:128] dest
  - [127:96] rkd_value (store data), [95:64] alu_src2, [63:32] alu_src1, [31:0] pc
- ex_to_ma_bus  output  71  {res_from_mem[70], gr_we[69], dest[68:64], ex_result[63:32], pc[31:0]}
- ex_to_id_bus  output  6  {gr_we&valid, dest&{5{valid}}}, used by decode for hazard detection
- data_sram_en  output  1  SRAM request enable
- data_sram_we  output  4  byte write enables
- data_sram_addr  output  32  byte address
- data_sram_wdata  output  32  store data

## Operation
- Internal state is a `valid` register plus a 151-bit bundle register.
  - `valid` loads id_validout whenever ex_allowin=1.
  - The bundle register loads only when id_validout & ex_allowin.
- Handshake:
  - ex_allowin = ~valid | (readygo & ma_allowin)
  - ex_validout = valid & readygo
- ALU, combinational on the registered operands:
  - add and sub are modulo 2^32.
  - slt compares signed; sltu compares unsigned. Both return 0 or 1.
  - The shift amount is alu_src2[4:0]; sra is arithmetic.
  - lui returns alu_src2.
  - If alu_op is all-zero, the result is 0.
- ex_result is the divider result when div_en is set (in the EX_DIV_EN build); otherwise it is the ALU result.
- Memory request:
  - data_sram_en = valid & readygo & ma_allowin & (res_from_mem | mem_we), so the read data is valid during the instruction's first cycle in memory access.
  - data_sram_we = {4{mem_we & data_sram_en}}. Stores are word-only.
  - data_sram_addr = ALU result.
  - data_sram_wdata = rkd_value.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE → BUSY when valid & div_en. This captures |src1| and |src2| (absolute values in signed mode), clears a 5-bit counter, and records the result signs.
  - BUSY performs one restoring radix-2 step per cycle and increments the counter. It moves to DONE after the step with counter == 31 (32 steps).
  - DONE → IDLE on the cycle the bundle is handed off (ma_allowin=1).
  - readygo = ~div_en | (state == DONE).
- Divider result:
  - Quotient is negated if the operand signs differ (signed mode).
  - Remainder takes the sign of the dividend.
  - div_rem selects remainder, otherwise quotient.
  - Divisor 0: quotient 0xFFFFFFFF, remainder equals the original dividend, in both signed and unsigned modes.
  - 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0.

## Timing
- Reset values: valid=0, bundle register 0, FSM IDLE, counter 0.
  - Consequently ex_validout=0, ex_allowin=1, data_sram_en=0, data_sram_we=0, ex_to_ma_bus=0, ex_to_id_bus=0.
- Non-divide instruction: latency 1. It is accepted at edge N and presented to memory access during cycle N→N+1.
- Divide: accepted at edge N. The FSM is IDLE during cycle N and BUSY during cycles N+1..N+32. DONE (ex_validout=1) is reached in cycle N+33.
- ma_allowin=0 with valid & readygo: the bundle, the result, and the DONE state hold. No SRAM request is issued.
- Simultaneous hand-off and accept: the new bundle replaces the old one in the same edge. If the new bundle is a divide, it starts from IDLE in the next cycle.
- Reset asserted mid-divide: FSM returns to IDLE and valid clears at that edge. No partial result escapes.

## Configuration
- EX_DIV_EN defined:
  - Divider and FSM are present.
  - readygo is as specified under Operation.
- EX_DIV_EN undefined:
  - No divider logic.
  - id_to_ex_bus[150:148] is ignored.
  - readygo is constant 1.
  - ex_result is always the ALU result.

## Test plan
- add: src1=0x7FFFFFFF, src2=1, gr_we=1, dest=5, ma_allowin=1 → one cycle later, ex_to_ma_bus[63:32]=0x80000000; ex_to_id_bus=6'b1_00101; data_sram_en=0.
- Store: mem_we=1, add, src1=0x1000, src2=4, rkd_value=0xDEADBEEF → in the hand-off cycle, data_sram_en=1, we=4'hF, addr=0x1004, wdata=0xDEADBEEF. Repeat with ma_allowin=0 → en=0 until ma_allowin rises.
- Signed divide (EX_DIV_EN): src1=-7, src2=2 → ex_validout=1 exactly 33 cycles after acceptance, quotient 0xFFFFFFFD. With div_rem=1, the result is 0xFFFFFFFF. ex_allowin stays 0 throughout BUSY.
- Divide by zero: unsigned 0x12345678/0 → quotient 0xFFFFFFFF; with div_rem=1, remainder 0x12345678. Signed 0x80000000/0xFFFFFFFF → 0x80000000.
- Back-pressure and reset: with a divide in BUSY at step 10, assert rst for one cycle → next cycle valid=0, ex_allowin=1, FSM IDLE. A following sra with src1=0x80000000, src2=4 yields 0xF8000000.
